// File: rtl/rw_pkg.sv
// Shared types for the read/write bus master: FSM states and queued op kinds.
// No logic and no latency of its own.
// No backpressure; type definitions only.
package rw_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // True when the op needs the upstream write-data qualifier before issue.
    function automatic logic needs_ready(input op_t op);
        return op == OP_WRITE;
    endfunction

endpackage

// File: rtl/rw_cmd_fifo.sv
// Command queue holding pending op kinds in arrival order; full/empty are registered.
// Push is visible at the head one cycle after the push edge.
// Push while full is dropped unless a pop happens on the same edge.
module rw_cmd_fifo
    import rw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  op_t  push_op,
    input  logic pop,
    output logic full,
    output logic empty,
    output op_t  head_op
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    op_t              mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot on the same edge, so a push into a full queue is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_op = mem[rd_ptr];

    // Occupancy after this edge, used to register exact full/empty flags.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and status flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: entries are only observed while the queue is non-empty.
    always_ff @(posedge clock) begin
        if (do_push && !reset) mem[wr_ptr] <= push_op;
    end

endmodule

// File: rtl/rw_bus_master.sv
// Queues read/write commands and issues them strictly in order on a valid/ack bus.
// Op enqueued into an idle, empty master shows bus_valid one edge later; min 2 cycles per op.
// Write head waits for ready and blocks younger ops; bus_valid holds until bus_ack.
module rw_bus_master
    import rw_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic              ready,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err_conflict,
    output logic              err_overflow
);

    state_t            state;
    state_t            state_nxt;
    logic              enq_req;
    op_t               enq_op;
    logic              pop;
    op_t               head_op;
    logic              q_full;
    logic              q_empty;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    // Exactly one of read/write requests an enqueue; both at once is a conflict.
    assign enq_req = read ^ write;
    assign enq_op  = write ? OP_WRITE : OP_READ;
    // The head retires only on an ack that arrives while the request is on the bus.
    assign pop     = (state == REQ) && bus_ack;

    rw_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (enq_req),
        .push_op(enq_op),
        .pop    (pop),
        .full   (q_full),
        .empty  (q_empty),
        .head_op(head_op)
    );

    // Issue the head when it can go; returning to IDLE on ack forces a gap between ops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!q_empty && (!needs_ready(head_op) || ready)) state_nxt = REQ;
            end
            REQ: begin
                if (bus_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register; reset abandons any outstanding request.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Address advances and the matching completion counter saturates on each retired op.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr   <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (pop) begin
            addr <= addr + 1'b1;
            if (head_op == OP_WRITE) begin
                if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
            end else begin
                if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_conflict <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (read && write)             err_conflict <= 1'b1;
            if (enq_req && q_full && !pop) err_overflow <= 1'b1;
        end
    end

    // Outputs come straight from registered state.
    assign bus_valid = (state == REQ);
    assign bus_we    = (state == REQ) && (head_op == OP_WRITE);
    assign bus_addr  = addr;
    assign full      = q_full;
    assign empty     = q_empty;
    assign rd_count  = rd_cnt;
    assign wr_count  = wr_cnt;

endmodule

// File: doc/rw_bus_master.md
RW_BUS_MASTER -- requirements
Module: rw_bus_master

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command queue depth, power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 8: bus address width.
REQ-003 SHALL have parameter CNT_W, default 16: completion counter width.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on posedge clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port read, input, 1 bit: read command request, sampled each posedge.
REQ-007 SHALL have port write, input, 1 bit: write command request, sampled each posedge.
REQ-008 SHALL have port ready, input, 1 bit: upstream write-data-ready qualifier.
REQ-009 SHALL have port bus_valid, output, 1 bit: bus request active.
REQ-010 SHALL have port bus_we, output, 1 bit: 1 = write, 0 = read; meaningful only while bus_valid.
REQ-011 SHALL have port bus_addr, output, ADDR_W bits: transaction address.
REQ-012 SHALL have port bus_ack, input, 1 bit: bus completion, one-cycle pulse.
REQ-013 SHALL have ports full and empty, output, 1 bit each: queue status.
REQ-014 SHALL have ports rd_count and wr_count, output, CNT_W bits each: completed reads and completed writes.
REQ-015 SHALL have ports err_conflict and err_overflow, output, 1 bit each: sticky error flags.

Function
REQ-016 SHALL enqueue a READ op at a posedge where read=1 and write=0, and a WRITE op where write=1 and read=0.
REQ-017 SHALL enqueue nothing and set err_conflict at a posedge where read=1 and write=1.
REQ-018 SHALL drop an enqueue attempted while full with no same-edge pop, and SHALL set err_overflow.
REQ-019 SHALL accept the enqueue when full and a pop happen on the same edge; the count stays DEPTH.
REQ-020 SHALL use the FSM states IDLE and REQ.
REQ-021 IDLE->REQ: SHALL occur when the queue is non-empty and the head is READ, or the head is WRITE and ready=1.
REQ-022 A WRITE head with ready=0 SHALL hold the FSM in IDLE and block later ops (strict in-order).
REQ-023 In REQ, SHALL drive bus_valid=1, bus_we=head op and bus_addr=address counter, all held stable until bus_ack.
REQ-024 REQ->IDLE on bus_ack: SHALL pop the head, increment the address counter modulo 2^ADDR_W, and increment rd_count or wr_count.
REQ-025 bus_ack in IDLE SHALL be ignored.
REQ-026 rd_count and wr_count SHALL saturate at all-ones.
REQ-027 SHALL insert at least one IDLE cycle between transactions, giving a peak throughput of one op per 2 cycles.
REQ-028 Latency: an op enqueued at edge k into an empty queue with an idle FSM SHALL give bus_valid=1 in the cycle following edge k+1.
REQ-029 full and empty SHALL be registered and exact: full when DEPTH ops are held, empty when 0 are held.

Reset
REQ-030 While reset=1 at a posedge, SHALL set FSM=IDLE, queue empty, address counter 0, counts 0 and error flags 0, and SHALL ignore read and write.
REQ-031 Reset values SHALL be: bus_valid=0, bus_we=0, bus_addr=0, full=0, empty=1, rd_count=0, wr_count=0, err_conflict=0, err_overflow=0.
REQ-032 Reset asserted mid-transaction SHALL drop bus_valid after the reset edge and discard the outstanding op without counting it.
REQ-033 Error flags SHALL clear only on reset.

Structure
REQ-034 Package rw_pkg SHALL hold the FSM state enum (IDLE, REQ) and the op enum (OP_READ, OP_WRITE).
REQ-035 The queue SHALL be a sub-module rw_cmd_fifo, parameterised by DEPTH, with push, pop, full, empty and head-op signals.
REQ-036 All outputs SHALL be registered or decoded from registered state only, with no input-to-output combinational path.

Verification
REQ-037 Reset, then read=1 for one edge (edge 1), bus_ack=1 in the first bus_valid cycle -> bus_valid=1, bus_we=0, bus_addr=0 after edge 2; rd_count=1 and empty=1 after edge 3.
REQ-038 Enqueue WRITE with ready=0 for 5 cycles, then ready=1 -> bus_valid stays 0 until one edge after ready rises; then bus_we=1, and wr_count=1 after ack.
REQ-039 read=1 and write=1 at the same edge -> queue unchanged, err_conflict=1 and held through 10 further cycles.
REQ-040 Hold bus_ack=0 and push 5 reads with DEPTH=4 -> full=1 after the 4th push, err_overflow=1 after the 5th, and exactly 4 ops complete once acks resume.
REQ-041 Complete 256 ops with ADDR_W=8 -> bus_addr wraps from 255 to 0; set CNT_W=4, complete 20 reads -> rd_count=15.
REQ-042 Assert reset in a REQ cycle with ack withheld -> bus_valid=0 and all counts 0 after the edge; a subsequent op issues at addr 0.
